// File: rtl/vending_core_multi.sv
// Multi-product vending controller: coin credit with saturation, selection/vend,
// cancel refund and coin-by-coin change return. All outputs are registered.
module vending_core_multi #(
  parameter int unsigned NUM_ITEMS  = 4,
  parameter int unsigned CREDIT_W   = 8,
  parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICES = {8'd75, 8'd50, 8'd35, 8'd25},
  parameter int unsigned STOCK_W    = 4,
  parameter int unsigned STOCK_INIT = 5,
  parameter int unsigned MAX_CREDIT = 200,
  localparam int unsigned IDX_W     = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic [2:0]          coin_in,
  input  logic                sel_valid,
  input  logic [IDX_W-1:0]    sel_idx,
  input  logic                cancel,
  input  logic                restock,
  output logic [CREDIT_W-1:0] credit,
  output logic                vend_valid,
  output logic [IDX_W-1:0]    vend_idx,
  output logic [2:0]          change_out,
  output logic                coin_reject,
  output logic                sold_out,
  output logic                short_credit,
  output logic                busy,
  output logic [1:0]          state_dbg
);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StCredit = 2'd1,
    StVend   = 2'd2,
    StChange = 2'd3
  } state_e;

  localparam logic [CREDIT_W-1:0] Val5      = CREDIT_W'(5);
  localparam logic [CREDIT_W-1:0] Val10     = CREDIT_W'(10);
  localparam logic [CREDIT_W-1:0] Val25     = CREDIT_W'(25);
  localparam logic [CREDIT_W:0]   MaxCredit = (CREDIT_W + 1)'(MAX_CREDIT);
  localparam logic [IDX_W:0]      NumItemsW = (IDX_W + 1)'(NUM_ITEMS);
  localparam logic [STOCK_W-1:0]  StockInit = STOCK_W'(STOCK_INIT);

  state_e                             state_q, state_d;
  logic [CREDIT_W-1:0]                credit_q, credit_d;
  logic [NUM_ITEMS-1:0][STOCK_W-1:0]  stock_q, stock_d;
  logic [IDX_W-1:0]                   sel_q, sel_d;
  logic [IDX_W-1:0]                   vend_idx_q, vend_idx_d;
  logic                               vend_valid_q, vend_valid_d;
  logic [2:0]                         change_q, change_d;
  logic                               reject_q, reject_d;
  logic                               sold_q, sold_d;
  logic                               short_q, short_d;
  logic                               busy_q, busy_d;

  logic [CREDIT_W-1:0] sel_price, vend_price, coin_val, chg_val;
  logic [STOCK_W-1:0]  sel_stock;
  logic [CREDIT_W:0]   coin_sum;
  logic                sel_ok, coin_legal, acted;

  always_comb begin
    sel_price  = '0;
    vend_price = '0;
    sel_stock  = '0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      if (sel_idx == IDX_W'(i)) begin
        sel_price = PRICES[i*CREDIT_W +: CREDIT_W];
        sel_stock = stock_q[i];
      end
      if (sel_q == IDX_W'(i)) begin
        vend_price = PRICES[i*CREDIT_W +: CREDIT_W];
      end
    end
    sel_ok = ({1'b0, sel_idx} < NumItemsW);

    coin_legal = 1'b1;
    unique case (coin_in)
      3'b001:  coin_val = Val5;
      3'b010:  coin_val = Val10;
      3'b100:  coin_val = Val25;
      default: begin
        coin_val   = '0;
        coin_legal = 1'b0;
      end
    endcase
    coin_sum = {1'b0, credit_q} + {1'b0, coin_val};

    // Greedy change: largest coin not exceeding the remaining credit.
    if (credit_q >= Val25) begin
      chg_val = Val25;
    end else if (credit_q >= Val10) begin
      chg_val = Val10;
    end else if (credit_q >= Val5) begin
      chg_val = Val5;
    end else begin
      chg_val = '0;
    end
  end

  always_comb begin
    state_d      = state_q;
    credit_d     = credit_q;
    stock_d      = stock_q;
    sel_d        = sel_q;
    vend_idx_d   = vend_idx_q;
    vend_valid_d = 1'b0;
    change_d     = 3'b000;
    reject_d     = 1'b0;
    sold_d       = 1'b0;
    short_d      = 1'b0;
    acted        = 1'b0;

    if (ena) begin
      unique case (state_q)
        StIdle, StCredit: begin
          if (cancel && (credit_q != '0)) begin
            acted   = 1'b1;
            state_d = StChange;
          end else if (sel_valid && sel_ok) begin
            acted = 1'b1;
            if (sel_stock == '0) begin
              sold_d = 1'b1;
            end else if (credit_q < sel_price) begin
              short_d = 1'b1;
            end else begin
              sel_d   = sel_idx;
              state_d = StVend;
            end
          end
          if (coin_in != 3'b000) begin
            if (acted || !coin_legal || (coin_sum > MaxCredit)) begin
              reject_d = 1'b1;
            end else begin
              credit_d = coin_sum[CREDIT_W-1:0];
              state_d  = StCredit;
            end
          end
          if (restock && (state_q == StIdle)) begin
            for (int i = 0; i < NUM_ITEMS; i++) stock_d[i] = StockInit;
          end
        end
        StVend: begin
          vend_valid_d = 1'b1;
          vend_idx_d   = sel_q;
          credit_d     = credit_q - vend_price;
          for (int i = 0; i < NUM_ITEMS; i++) begin
            if (sel_q == IDX_W'(i)) stock_d[i] = stock_q[i] - STOCK_W'(1);
          end
          state_d  = (credit_d != '0) ? StChange : StIdle;
          reject_d = (coin_in != 3'b000);
        end
        StChange: begin
          if (chg_val == Val25) begin
            change_d = 3'b100;
          end else if (chg_val == Val10) begin
            change_d = 3'b010;
          end else if (chg_val == Val5) begin
            change_d = 3'b001;
          end
          // A sub-5 remainder cannot be paid out, so it is dropped.
          credit_d = (chg_val == '0) ? '0 : credit_q - chg_val;
          if (credit_d == '0) state_d = StIdle;
          reject_d = (coin_in != 3'b000);
        end
        default: state_d = StIdle;
      endcase
    end

    busy_d = (state_d == StVend) || (state_d == StChange);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      credit_q     <= '0;
      for (int i = 0; i < NUM_ITEMS; i++) stock_q[i] <= StockInit;
      sel_q        <= '0;
      vend_idx_q   <= '0;
      vend_valid_q <= 1'b0;
      change_q     <= 3'b000;
      reject_q     <= 1'b0;
      sold_q       <= 1'b0;
      short_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      credit_q     <= credit_d;
      stock_q      <= stock_d;
      sel_q        <= sel_d;
      vend_idx_q   <= vend_idx_d;
      vend_valid_q <= vend_valid_d;
      change_q     <= change_d;
      reject_q     <= reject_d;
      sold_q       <= sold_d;
      short_q      <= short_d;
      busy_q       <= busy_d;
    end
  end

  assign credit       = credit_q;
  assign vend_valid   = vend_valid_q;
  assign vend_idx     = vend_idx_q;
  assign change_out   = change_q;
  assign coin_reject  = reject_q;
  assign sold_out     = sold_q;
  assign short_credit = short_q;
  assign busy         = busy_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_vending_core_multi.sv
// Scoreboard bench for vending_core_multi: a transaction-level model predicts each
// cycle's registered outputs; a monitor pops and compares them after every clock edge.
module tb_vending_core_multi;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic [2:0] coin_in = 3'b000;
  logic       sel_valid = 1'b0;
  logic [1:0] sel_idx = 2'd0;
  logic       cancel = 1'b0;
  logic       restock = 1'b0;
  logic [7:0] credit;
  logic       vend_valid;
  logic [1:0] vend_idx;
  logic [2:0] change_out;
  logic       coin_reject, sold_out, short_credit, busy;
  logic [1:0] state_dbg;

  vending_core_multi #(
    .NUM_ITEMS (4),
    .CREDIT_W  (8),
    .PRICES    ({8'd75, 8'd50, 8'd35, 8'd25}),
    .STOCK_W   (4),
    .STOCK_INIT(5),
    .MAX_CREDIT(200)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .coin_in     (coin_in),
    .sel_valid   (sel_valid),
    .sel_idx     (sel_idx),
    .cancel      (cancel),
    .restock     (restock),
    .credit      (credit),
    .vend_valid  (vend_valid),
    .vend_idx    (vend_idx),
    .change_out  (change_out),
    .coin_reject (coin_reject),
    .sold_out    (sold_out),
    .short_credit(short_credit),
    .busy        (busy),
    .state_dbg   (state_dbg)
  );

  always #5 clk = ~clk;

  // Item i price, item0 taken from the least-significant byte of PRICES.
  int price_tab[N] = '{25, 35, 50, 75};

  int n_pass = 0;
  int n_total = 0;
  logic [20:0] exp_q[$];
  bit mon_en = 1'b0;

  // Model: credit, stock, and the list of pending busy-mode actions
  // (100+idx = vend of idx, 5/10/25 = coin to return).
  int m_credit;
  int m_stock[N];
  int m_pend[$];

  function automatic logic [20:0] pack(bit v, int vi, logic [2:0] ch, bit rj, bit so, bit sc,
                                       bit bz, int st, int cr);
    return {v, 3'(vi), ch, rj, so, sc, bz, 2'(st), 8'(cr)};
  endfunction

  function automatic int coin_val(logic [2:0] c);
    case (c)
      3'b001:  return 5;
      3'b010:  return 10;
      3'b100:  return 25;
      default: return 0;
    endcase
  endfunction

  function automatic logic [2:0] coin_code(int v);
    if (v == 25) return 3'b100;
    if (v == 10) return 3'b010;
    return 3'b001;
  endfunction

  function automatic void push_change(int c);
    int r = c;
    while (r >= 25) begin m_pend.push_back(25); r -= 25; end
    while (r >= 10) begin m_pend.push_back(10); r -= 10; end
    while (r >= 5)  begin m_pend.push_back(5);  r -= 5;  end
  endfunction

  function automatic void model_reset();
    m_credit = 0;
    for (int i = 0; i < N; i++) m_stock[i] = 5;
    m_pend.delete();
  endfunction

  task automatic check(string name, logic [20:0] act, logic [20:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %h required %h", name, $time, act, exp);
  endtask

  function automatic logic [20:0] dut_vec();
    return pack(vend_valid, vend_valid ? int'(vend_idx) : 0, change_out, coin_reject, sold_out,
                short_credit, busy, int'(state_dbg), int'(credit));
  endfunction

  task automatic drive(logic [2:0] c, bit sv, int idx, bit cn, bit rs, bit en = 1'b1);
    bit v = 0, rj = 0, so = 0, sc = 0, acted = 0, was_idle;
    logic [2:0] ch = 3'b000;
    int vi = 0, a, st;
    @(negedge clk);
    rst_n = 1'b1; ena = en; coin_in = c; sel_valid = sv; sel_idx = 2'(idx);
    cancel = cn; restock = rs;
    if (en) begin
      if (m_pend.size() > 0) begin
        a = m_pend.pop_front();
        if (a >= 100) begin
          v = 1; vi = a - 100;
          m_credit -= price_tab[vi];
          m_stock[vi]--;
        end else begin
          ch = coin_code(a);
          m_credit -= a;
        end
        if (c != 3'b000) rj = 1;
      end else begin
        was_idle = (m_credit == 0);
        if (cn && m_credit > 0) begin
          acted = 1;
          push_change(m_credit);
        end else if (sv) begin
          acted = 1;
          if (m_stock[idx] == 0) so = 1;
          else if (m_credit < price_tab[idx]) sc = 1;
          else begin
            m_pend.push_back(100 + idx);
            push_change(m_credit - price_tab[idx]);
          end
        end
        if (c != 3'b000) begin
          if (acted || coin_val(c) == 0 || m_credit + coin_val(c) > 200) rj = 1;
          else m_credit += coin_val(c);
        end
        if (rs && was_idle) for (int i = 0; i < N; i++) m_stock[i] = 5;
      end
    end
    if (m_pend.size() > 0) st = (m_pend[0] >= 100) ? 2 : 3;
    else st = (m_credit > 0) ? 1 : 0;
    exp_q.push_back(pack(v, vi, ch, rj, so, sc, m_pend.size() > 0, st, m_credit));
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) drive(3'b000, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; ena = 1'b1; coin_in = 3'b000; sel_valid = 0; cancel = 0; restock = 0;
    #1;
    check("async_reset", dut_vec(), pack(0, 0, 3'b000, 0, 0, 0, 0, 0, 0));
    model_reset();
    exp_q.push_back(pack(0, 0, 3'b000, 0, 0, 0, 0, 0, 0));
  endtask

  initial begin : monitor
    logic [20:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL scoreboard_underflow at %0t: got no entry required one", $time);
        end else begin
          e = exp_q.pop_front();
          check("cycle_outputs", dut_vec(), e);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout required $finish");
    $fatal(1);
  end

  initial begin : stim
    logic [2:0] c;
    int r;
    model_reset();
    #1;
    check("reset_state", dut_vec(), pack(0, 0, 3'b000, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    mon_en = 1'b1;
    exp_q.push_back(pack(0, 0, 3'b000, 0, 0, 0, 0, 0, 0));

    // 50 credit, select the 50-priced item: exact vend, no change.
    drive(3'b100, 0, 0, 0, 0); drive(3'b100, 0, 0, 0, 0);
    drive(3'b000, 1, 2, 0, 0); idle(4);
    // 60 credit, 35 item: vend then change 25 exactly once.
    drive(3'b100, 0, 0, 0, 0); drive(3'b100, 0, 0, 0, 0); drive(3'b010, 0, 0, 0, 0);
    drive(3'b000, 1, 1, 0, 0); idle(4);
    // Saturate at 200, overflow coin rejected, cancel returns 8x25.
    for (int i = 0; i < 8; i++) drive(3'b100, 0, 0, 0, 0);
    drive(3'b001, 0, 0, 0, 0);
    drive(3'b000, 0, 0, 1, 0); idle(10);
    // Deplete item0, sold_out, restock ignored in CREDIT, honoured in IDLE.
    for (int k = 0; k < 5; k++) begin
      drive(3'b100, 0, 0, 0, 0); drive(3'b000, 1, 0, 0, 0); idle(2);
    end
    drive(3'b100, 0, 0, 0, 0); drive(3'b000, 1, 0, 0, 0);
    drive(3'b000, 0, 0, 0, 1); drive(3'b000, 1, 0, 0, 0);
    drive(3'b000, 0, 0, 1, 0); idle(3);
    drive(3'b000, 0, 0, 0, 1);
    drive(3'b100, 0, 0, 0, 0); drive(3'b000, 1, 0, 0, 0); idle(3);
    // Illegal coin, short credit, coin alongside a valid vend.
    drive(3'b011, 0, 0, 0, 0);
    drive(3'b010, 0, 0, 0, 0); drive(3'b000, 1, 3, 0, 0);
    drive(3'b100, 0, 0, 0, 0); drive(3'b100, 0, 0, 0, 0); drive(3'b100, 0, 0, 0, 0);
    drive(3'b001, 1, 3, 0, 0); idle(4);
    // Reset during change with 30 credit; then ena=0 with coin strobes.
    drive(3'b100, 0, 0, 0, 0); drive(3'b001, 0, 0, 0, 0); drive(3'b000, 0, 0, 1, 0);
    do_reset();
    drive(3'b010, 0, 0, 0, 0);
    drive(3'b100, 0, 0, 0, 0, 0); drive(3'b001, 1, 0, 1, 0, 0); drive(3'b010, 0, 0, 0, 0, 0);
    idle(2);
    drive(3'b000, 0, 0, 1, 0); idle(3);

    for (int i = 0; i < 800; i++) begin
      r = $urandom_range(0, 99);
      if (r < 45) begin
        r = $urandom_range(0, 9);
        if (r < 3) c = 3'b001;
        else if (r < 6) c = 3'b010;
        else if (r < 9) c = 3'b100;
        else c = 3'($urandom_range(3, 7)) | 3'b011 & 3'b111;
        if (coin_val(c) != 0 && r == 9) c = 3'b110;
      end else begin
        c = 3'b000;
      end
      if ($urandom_range(0, 199) == 0) do_reset();
      else drive(c, $urandom_range(0, 99) < 20, $urandom_range(0, 3),
                 $urandom_range(0, 99) < 4, $urandom_range(0, 99) < 4,
                 $urandom_range(0, 99) < 92);
    end
    idle(10);

    @(posedge clk);
    #2;
    n_total++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: got %0d entries left required 0", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
